timer_regs: RTL and testbench
=============================

TIMER_REGS -- requirements
Module: timer_regs

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, width of usr_addr.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register width; only 32 supported.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port usr_addr  input  ADDR_WIDTH  byte address from the AXI-Lite slave stage.
REQ-006 SHALL have port usr_wdata  input  32  write data.
REQ-007 SHALL have port usr_wstrb  input  4  byte enables for usr_wdata.
REQ-008 SHALL have port usr_wen  input  1  one-cycle write strobe.
REQ-009 SHALL have port usr_ren  input  1  one-cycle read strobe.
REQ-010 SHALL have port usr_rdata  output  32  read data.
REQ-011 SHALL have port irq  output  1  level interrupt.

Function
REQ-012 SHALL decode usr_addr[7:2] only: 0x00 CTRL, 0x04 STATUS, 0x08 COUNT_LO, 0x0C COUNT_HI, 0x10 CMP_LO, 0x14 CMP_HI; other offsets read 0, writes ignored.
REQ-013 SHALL define CTRL as bit0 EN, bit1 IRQ_EN, bit2 AUTO_RELOAD, bits[15:8] PRESCALE; other bits read 0.
REQ-014 SHALL drive usr_rdata combinationally from usr_addr and register state, zero-latency, with no dependence on usr_ren.
REQ-015 SHALL apply writes to CTRL, COUNT_LO/HI and CMP_LO/HI per byte lane on the usr_wen edge.
REQ-016 SHALL hold a prescale counter at 0 while EN=0; while EN=1, count 0..PRESCALE and produce a one-cycle tick when it equals PRESCALE, then wrap to 0.
REQ-017 SHALL tick every cycle when PRESCALE=0.
REQ-018 SHALL, on tick, load the 64-bit count with 0 if AUTO_RELOAD=1 and count==CMP; otherwise load count+1 with wrap from 2^64-1 to 0.
REQ-019 SHALL set STATUS.MATCH (bit0) on any tick where count==CMP; MATCH is sticky.
REQ-020 SHALL clear MATCH on a write to STATUS with usr_wdata[0]=1 and usr_wstrb[0]=1; a simultaneous set SHALL win.
REQ-021 SHALL give a usr_wen write to COUNT_LO/HI priority over a same-cycle tick update of that half; the other half keeps its tick update.
REQ-022 SHALL capture count[63:32] into a HI shadow register when usr_ren=1 and the offset is COUNT_LO; reads of COUNT_HI return the shadow.
REQ-023 SHALL drive irq = MATCH & IRQ_EN combinationally from registers.
REQ-024 SHALL change no state on usr_ren except the shadow capture.

Reset
REQ-025 SHALL reset CTRL, STATUS, count, shadow and prescale counter to 0 and CMP to 0xFFFF_FFFF_FFFF_FFFF.
REQ-026 SHALL drive irq=0 and usr_rdata per REQ-014 from reset values; reset mid-count SHALL discard any pending tick.

Structure
REQ-027 SHALL keep register offsets and CTRL bit positions in shared package timer_regs_pkg.
REQ-028 SHALL implement the prescale counter and tick generation in sub-module timer_prescaler, with ports clk, rst, en, prescale[7:0], tick.

Verification
REQ-029 SHALL test: reset, then read all offsets -> CTRL=0, STATUS=0, COUNT=0, CMP_LO=CMP_HI=0xFFFFFFFF, irq=0.
REQ-030 SHALL test: CTRL=0x0000_0301 (EN, PRESCALE=3) -> count advances by 1 every 4 cycles; 40 cycles -> count=10.
REQ-031 SHALL test: CMP=5, CTRL=0x7 (EN, IRQ_EN, AUTO_RELOAD, PRESCALE=0) -> sequence 0..5,0,1...; MATCH and irq rise on the tick at count=5.
REQ-032 SHALL test: W1C STATUS=0x1 on the same cycle as a match tick -> MATCH stays 1; W1C on the next non-match cycle -> MATCH=0, irq=0.
REQ-033 SHALL test: COUNT_HI=0x1, COUNT_LO=0xFFFF_FFFF, EN=1, PRESCALE=0 -> read LO then HI returns a consistent 64-bit snapshot across the carry to 0x2_0000_0000.
REQ-034 SHALL test: write COUNT_LO=0x1234 with wstrb=4'b0001 on a tick cycle -> COUNT_LO byte0=0x34 and the upper bytes are unchanged.

Source files
------------

// File: rtl/timer_regs_pkg.sv
// Shared register map, CTRL bit positions and byte-lane helpers for the timer block.
// Pure declarations; no timing or flow control of its own.
package timer_regs_pkg;

  localparam int REG_W = 32;

  // Word indices (usr_addr[7:2]) and the matching byte offsets
  localparam logic [5:0] IDX_CTRL     = 6'h00;
  localparam logic [5:0] IDX_STATUS   = 6'h01;
  localparam logic [5:0] IDX_COUNT_LO = 6'h02;
  localparam logic [5:0] IDX_COUNT_HI = 6'h03;
  localparam logic [5:0] IDX_CMP_LO   = 6'h04;
  localparam logic [5:0] IDX_CMP_HI   = 6'h05;

  localparam logic [7:0] OFF_CTRL     = {IDX_CTRL, 2'b00};
  localparam logic [7:0] OFF_STATUS   = {IDX_STATUS, 2'b00};
  localparam logic [7:0] OFF_COUNT_LO = {IDX_COUNT_LO, 2'b00};
  localparam logic [7:0] OFF_COUNT_HI = {IDX_COUNT_HI, 2'b00};
  localparam logic [7:0] OFF_CMP_LO   = {IDX_CMP_LO, 2'b00};
  localparam logic [7:0] OFF_CMP_HI   = {IDX_CMP_HI, 2'b00};

  localparam int CTRL_EN_BIT          = 0;
  localparam int CTRL_IRQ_EN_BIT      = 1;
  localparam int CTRL_AUTO_RELOAD_BIT = 2;
  localparam int CTRL_PRESCALE_LSB    = 8;
  localparam int STATUS_MATCH_BIT     = 0;

  typedef struct packed {
    logic [7:0] prescale;
    logic       auto_reload;
    logic       irq_en;
    logic       en;
  } ctrl_t;

  function automatic logic [REG_W-1:0] apply_wstrb(input logic [REG_W-1:0] old_val,
                                                   input logic [REG_W-1:0] wdata,
                                                   input logic [3:0]       strb);
    logic [REG_W-1:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

  function automatic logic [REG_W-1:0] ctrl_to_word(input ctrl_t c);
    logic [REG_W-1:0] w;
    w = '0;
    w[CTRL_EN_BIT]                  = c.en;
    w[CTRL_IRQ_EN_BIT]              = c.irq_en;
    w[CTRL_AUTO_RELOAD_BIT]         = c.auto_reload;
    w[CTRL_PRESCALE_LSB +: 8]       = c.prescale;
    return w;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescale divider: tick is high for one cycle every prescale+1 enabled cycles.
// Tick is combinational from the counter state; no backpressure, holds at 0 while disabled.
module timer_prescaler (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] prescale,
  output logic       tick
);

  logic [7:0] cnt;

  assign tick = en && (cnt == prescale);

  // >= also recovers cleanly if prescale is lowered below the running count
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt <= 8'd0;
    end else if (cnt >= prescale) begin
      cnt <= 8'd0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/timer_regs.sv
// 64-bit prescaled timer with compare/match interrupt behind a simple register port.
// Reads are zero-latency combinational, writes land on the usr_wen edge; no backpressure.
module timer_regs
  import timer_regs_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   usr_addr,
  input  logic [DATA_WIDTH-1:0]   usr_wdata,
  input  logic [DATA_WIDTH/8-1:0] usr_wstrb,
  input  logic                    usr_wen,
  input  logic                    usr_ren,
  output logic [DATA_WIDTH-1:0]   usr_rdata,
  output logic                    irq
);

  logic [5:0]  idx;
  logic        unused_addr;
  ctrl_t       ctrl;
  logic        match;
  logic [63:0] count;
  logic [63:0] cmp;
  logic [31:0] shadow_hi;
  logic        tick;

  logic        cnt_hit;
  logic        match_clr;
  logic [63:0] tick_val;
  logic [31:0] lo_nxt;
  logic [31:0] hi_nxt;

  assign idx         = usr_addr[7:2];
  assign unused_addr = ^{usr_addr[ADDR_WIDTH-1:8], usr_addr[1:0]};

  timer_prescaler u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (ctrl.en),
    .prescale (ctrl.prescale),
    .tick     (tick)
  );

  assign cnt_hit   = (count == cmp);
  assign match_clr = usr_wen && (idx == IDX_STATUS) &&
                     usr_wstrb[0] && usr_wdata[STATUS_MATCH_BIT];
  assign irq       = match & ctrl.irq_en;

  // A bus write to one count half overrides its tick update; the other half still advances
  always_comb begin
    tick_val = (ctrl.auto_reload && cnt_hit) ? 64'd0 : count + 64'd1;
    lo_nxt   = tick ? tick_val[31:0]  : count[31:0];
    hi_nxt   = tick ? tick_val[63:32] : count[63:32];
    if (usr_wen && (idx == IDX_COUNT_LO)) lo_nxt = apply_wstrb(count[31:0], usr_wdata, usr_wstrb);
    if (usr_wen && (idx == IDX_COUNT_HI)) hi_nxt = apply_wstrb(count[63:32], usr_wdata, usr_wstrb);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl      <= '0;
      match     <= 1'b0;
      count     <= 64'd0;
      cmp       <= '1;
      shadow_hi <= 32'd0;
    end else begin
      if (usr_wen && (idx == IDX_CTRL)) begin
        if (usr_wstrb[0]) begin
          ctrl.en          <= usr_wdata[CTRL_EN_BIT];
          ctrl.irq_en      <= usr_wdata[CTRL_IRQ_EN_BIT];
          ctrl.auto_reload <= usr_wdata[CTRL_AUTO_RELOAD_BIT];
        end
        if (usr_wstrb[1]) ctrl.prescale <= usr_wdata[CTRL_PRESCALE_LSB +: 8];
      end
      if (usr_wen && (idx == IDX_CMP_LO)) cmp[31:0]  <= apply_wstrb(cmp[31:0], usr_wdata, usr_wstrb);
      if (usr_wen && (idx == IDX_CMP_HI)) cmp[63:32] <= apply_wstrb(cmp[63:32], usr_wdata, usr_wstrb);
      count <= {hi_nxt, lo_nxt};
      match <= (tick && cnt_hit) || (match && !match_clr);
      // Reading LO freezes HI so a following HI read pairs with it across carries
      if (usr_ren && (idx == IDX_COUNT_LO)) shadow_hi <= count[63:32];
    end
  end

  always_comb begin
    usr_rdata = '0;
    case (idx)
      IDX_CTRL:     usr_rdata = ctrl_to_word(ctrl);
      IDX_STATUS:   usr_rdata[STATUS_MATCH_BIT] = match;
      IDX_COUNT_LO: usr_rdata = count[31:0];
      IDX_COUNT_HI: usr_rdata = shadow_hi;
      IDX_CMP_LO:   usr_rdata = cmp[31:0];
      IDX_CMP_HI:   usr_rdata = cmp[63:32];
      default:      usr_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_timer_regs.sv
// Directed bench for timer_regs: register table checks plus cycle-exact timer sequences.
module tb_timer_regs;
  import timer_regs_pkg::*;

  localparam logic [31:0] BASE = 32'hA5A5_0000;

  logic        clk;
  logic        rst;
  logic [31:0] usr_addr;
  logic [31:0] usr_wdata;
  logic [3:0]  usr_wstrb;
  logic        usr_wen;
  logic        usr_ren;
  logic [31:0] usr_rdata;
  logic        irq;

  int tests;
  int fails;

  timer_regs #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .usr_addr  (usr_addr),
    .usr_wdata (usr_wdata),
    .usr_wstrb (usr_wstrb),
    .usr_wen   (usr_wen),
    .usr_ren   (usr_ren),
    .usr_rdata (usr_rdata),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t rst_vec[8];
  vec_t rw_vec[12];

  function automatic vec_t mk(input logic w, input logic [7:0] a, input logic [31:0] d,
                              input logic [3:0] s, input logic [31:0] e, input string n);
    vec_t v;
    v.wr = w; v.addr = a; v.data = d; v.strb = s; v.exp = e; v.name = n;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Each access is issued at a negedge and spans exactly one rising edge
  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    usr_addr  = BASE | {24'h0, a};
    usr_wdata = d;
    usr_wstrb = s;
    usr_wen   = 1'b1;
    @(negedge clk);
    usr_wen   = 1'b0;
    usr_wstrb = 4'h0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d, output logic ir);
    usr_addr = BASE | {24'h0, a};
    usr_ren  = 1'b1;
    #1;
    d  = usr_rdata;
    ir = irq;
    @(negedge clk);
    usr_ren = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    logic [31:0] d;
    logic        ir;
    for (int i = 0; i < 8; i++) begin
      rd(rst_vec[i].addr, d, ir);
      chk({tag, rst_vec[i].name}, d, rst_vec[i].exp);
      chk({tag, "irq_", rst_vec[i].name}, {31'd0, ir}, 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic        ir;
    int          exp_cnt[9];
    int          exp_irq[9];

    tests = 0;
    fails = 0;
    clk = 1'b0; rst = 1'b1;
    usr_addr = '0; usr_wdata = '0; usr_wstrb = '0; usr_wen = 1'b0; usr_ren = 1'b0;

    rst_vec[0] = mk(0, OFF_CTRL,     0, 0, 32'h0000_0000, "ctrl");
    rst_vec[1] = mk(0, OFF_STATUS,   0, 0, 32'h0000_0000, "status");
    rst_vec[2] = mk(0, OFF_COUNT_LO, 0, 0, 32'h0000_0000, "count_lo");
    rst_vec[3] = mk(0, OFF_COUNT_HI, 0, 0, 32'h0000_0000, "count_hi");
    rst_vec[4] = mk(0, OFF_CMP_LO,   0, 0, 32'hFFFF_FFFF, "cmp_lo");
    rst_vec[5] = mk(0, OFF_CMP_HI,   0, 0, 32'hFFFF_FFFF, "cmp_hi");
    rst_vec[6] = mk(0, 8'h18,        0, 0, 32'h0000_0000, "unmapped_18");
    rst_vec[7] = mk(0, 8'hFC,        0, 0, 32'h0000_0000, "unmapped_fc");

    rw_vec[0]  = mk(1, OFF_CMP_LO, 32'h1122_3344, 4'b0101, 0, "");
    rw_vec[1]  = mk(0, OFF_CMP_LO, 0, 0, 32'hFF22_FF44, "cmp_lo_strb");
    rw_vec[2]  = mk(0, 8'h13,      0, 0, 32'hFF22_FF44, "cmp_lo_lowbits");
    rw_vec[3]  = mk(1, OFF_CTRL,   32'hFFFF_FFF8, 4'hF, 0, "");
    rw_vec[4]  = mk(0, OFF_CTRL,   0, 0, 32'h0000_FF00, "ctrl_mask");
    rw_vec[5]  = mk(1, OFF_CTRL,   32'h0000_0007, 4'b0010, 0, "");
    rw_vec[6]  = mk(0, OFF_CTRL,   0, 0, 32'h0000_0000, "ctrl_byte1_only");
    rw_vec[7]  = mk(1, 8'h18,      32'hDEAD_BEEF, 4'hF, 0, "");
    rw_vec[8]  = mk(0, 8'h18,      0, 0, 32'h0000_0000, "unmapped_wr");
    rw_vec[9]  = mk(1, OFF_CMP_LO, 32'hFFFF_FFFF, 4'hF, 0, "");
    rw_vec[10] = mk(0, OFF_CMP_LO, 0, 0, 32'hFFFF_FFFF, "cmp_lo_restore");
    rw_vec[11] = mk(0, OFF_COUNT_LO, 0, 0, 32'h0000_0000, "count_idle");

    repeat (2) @(negedge clk);
    rst = 1'b0;

    check_reset_values("rst_");

    for (int i = 0; i < 12; i++) begin
      if (rw_vec[i].wr) begin
        wr(rw_vec[i].addr, rw_vec[i].data, rw_vec[i].strb);
      end else begin
        rd(rw_vec[i].addr, d, ir);
        chk(rw_vec[i].name, d, rw_vec[i].exp);
      end
    end

    // Prescale 3: ticks land 4, 8, ... edges after EN takes effect
    wr(OFF_CTRL, 32'h0000_0301, 4'hF);
    repeat (39) @(negedge clk);
    rd(OFF_COUNT_LO, d, ir); chk("presc_39cyc", d, 32'd9);
    rd(OFF_COUNT_LO, d, ir); chk("presc_40cyc", d, 32'd10);
    wr(OFF_CTRL, 32'h0, 4'hF);
    repeat (6) @(negedge clk);
    rd(OFF_COUNT_LO, d, ir); chk("presc_disabled_hold", d, 32'd10);

    // Auto-reload at CMP=5 with prescale 0
    wr(OFF_COUNT_LO, 32'h0, 4'hF);
    wr(OFF_COUNT_HI, 32'h0, 4'hF);
    wr(OFF_CMP_LO, 32'd5, 4'hF);
    wr(OFF_CMP_HI, 32'h0, 4'hF);
    wr(OFF_CTRL, 32'h0000_0007, 4'hF);
    exp_cnt = '{0, 1, 2, 3, 4, 5, 0, 1, 2};
    exp_irq = '{0, 0, 0, 0, 0, 0, 1, 1, 1};
    for (int i = 0; i < 9; i++) begin
      rd(OFF_COUNT_LO, d, ir);
      chk($sformatf("reload_cnt_%0d", i), d, exp_cnt[i]);
      chk($sformatf("reload_irq_%0d", i), {31'd0, ir}, exp_irq[i]);
    end

    // W1C racing a match tick, then W1C on a quiet cycle
    rd(OFF_STATUS, d, ir); chk("match_sticky", d, 32'h1);
    @(negedge clk);
    wr(OFF_STATUS, 32'h1, 4'h1);
    rd(OFF_STATUS, d, ir);
    chk("w1c_vs_set_status", d, 32'h1);
    chk("w1c_vs_set_irq", {31'd0, ir}, 32'd1);
    wr(OFF_STATUS, 32'h1, 4'h1);
    rd(OFF_STATUS, d, ir);
    chk("w1c_status", d, 32'h0);
    chk("w1c_irq", {31'd0, ir}, 32'd0);
    wr(OFF_CTRL, 32'h0, 4'hF);

    // Snapshot across the LO->HI carry
    wr(OFF_CMP_LO, 32'hFFFF_FFFF, 4'hF);
    wr(OFF_CMP_HI, 32'hFFFF_FFFF, 4'hF);
    wr(OFF_COUNT_HI, 32'h1, 4'hF);
    wr(OFF_COUNT_LO, 32'hFFFF_FFFF, 4'hF);
    wr(OFF_CTRL, 32'h1, 4'hF);
    rd(OFF_COUNT_LO, d, ir); chk("snap1_lo", d, 32'hFFFF_FFFF);
    rd(OFF_COUNT_HI, d, ir); chk("snap1_hi", d, 32'h1);
    rd(OFF_COUNT_LO, d, ir); chk("snap2_lo", d, 32'h1);
    rd(OFF_COUNT_HI, d, ir); chk("snap2_hi", d, 32'h2);
    wr(OFF_CTRL, 32'h0, 4'hF);

    // Byte-lane write to LO on a carrying tick: HI keeps its tick update
    wr(OFF_COUNT_HI, 32'h0, 4'hF);
    wr(OFF_COUNT_LO, 32'hFFFF_FFFF, 4'hF);
    wr(OFF_CTRL, 32'h1, 4'hF);
    wr(OFF_COUNT_LO, 32'h0000_1234, 4'b0001);
    rd(OFF_COUNT_LO, d, ir); chk("lane_wr_lo", d, 32'hFFFF_FF34);
    rd(OFF_COUNT_HI, d, ir); chk("lane_wr_hi_tick", d, 32'h1);
    wr(OFF_CTRL, 32'h0, 4'hF);

    // Raise irq, confirm strobe-gated W1C, then reset with a tick pending
    wr(OFF_CMP_LO, 32'h10, 4'hF);
    wr(OFF_CMP_HI, 32'h0, 4'hF);
    wr(OFF_COUNT_LO, 32'h10, 4'hF);
    wr(OFF_COUNT_HI, 32'h0, 4'hF);
    wr(OFF_CTRL, 32'h3, 4'hF);
    @(negedge clk);
    #1 chk("irq_before_rst", {31'd0, irq}, 32'd1);
    wr(OFF_STATUS, 32'h1, 4'b1110);
    rd(OFF_STATUS, d, ir); chk("w1c_no_strb", d, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_values("midrst_");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
